// File: rtl/shift_pkg.sv
// Shared types and helpers for the iterative shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_NOP = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } shift_state_t;

  // Bit positions to shift this cycle: whatever remains, capped at the per-cycle step.
  function automatic int min_step(input int rem, input int step);
    return (rem < step) ? rem : step;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift of at most STEP positions; SRA replicates the current MSB.
module shift_step
  import shift_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int STEP = 8
) (
  input  logic [1:0]                  op,
  input  logic [$clog2(STEP+1)-1:0]   k,
  input  logic [XLEN-1:0]             a,
  output logic [XLEN-1:0]             y
);

  // Small barrel: k never exceeds STEP.
  always_comb begin
    y = a;
    unique case (shift_op_t'(op))
      SH_SLL:  y = a << k;
      SH_SRL:  y = a >> k;
      SH_SRA:  y = $signed(a) >>> k;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/shift_iter.sv
// Multi-cycle shifter: walks the shift amount down by up to STEP per cycle.
//
//  state | meaning
//  IDLE  | waiting for start; loads acc/rem/op on accept
//  RUN   | shifting acc by min(rem, STEP) each cycle
//  DONE  | one-cycle done pulse; dout bypasses acc and is registered
module shift_iter
  import shift_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int STEP = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [$clog2(XLEN)-1:0]  amt,
  input  logic [XLEN-1:0]          din,
  output logic                     busy,
  output logic                     done,
  output logic [XLEN-1:0]          dout
);

  localparam int AW = $clog2(XLEN);
  localparam int KW = $clog2(STEP+1);

  shift_state_t    state_q, state_d;
  shift_op_t       op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [AW-1:0]   rem_q, rem_d;
  logic [XLEN-1:0] dout_q, dout_d;

  int              k_int;
  logic [KW-1:0]   k;
  logic [AW-1:0]   load_rem;
  logic [XLEN-1:0] step_y;

  // Per-cycle step size; never larger than rem, so rem cannot underflow.
  always_comb begin
    k_int = min_step(int'(rem_q), STEP);
    k     = KW'(k_int);
  end

  shift_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
    .op (op_q),
    .k  (k),
    .a  (acc_q),
    .y  (step_y)
  );

  // Next-state logic for FSM and datapath registers.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    dout_d   = dout_q;
    load_rem = (op == 2'b11) ? '0 : amt;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = din;
          op_d    = shift_op_t'(op);
          rem_d   = load_rem;
          state_d = (load_rem == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_d   = step_y;
        rem_d   = rem_q - AW'(k_int);
        state_d = (int'(rem_q) <= STEP) ? DONE : RUN;
      end
      DONE: begin
        dout_d  = acc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation without touching dout beyond clearing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= SH_SLL;
      acc_q   <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
    end
  end

  // Outputs: dout shows the fresh result in the DONE cycle through the acc bypass.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    dout = done ? acc_q : dout_q;
  end

endmodule
